// File: rtl/filter_out_fifo.sv
// rtl/filter_out_fifo.sv - first-word-fall-through output FIFO with occupancy, high-water mark and drop counter
//
// Purpose: buffers samples from the upstream filter stage for a downstream
// consumer. The head entry is presented combinationally from the array
// (first-word-fall-through), so a sample pushed at edge N is visible right
// after edge N.
//
// Ports:
//   clk        in   single clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   i_data     in   WIDTH  sample from upstream
//   i_valid    in   i_data valid this cycle
//   o_ready    out  FIFO can accept a sample (not full)
//   o_data     out  WIDTH  head-of-queue sample, zero when empty
//   o_valid    out  o_data holds a sample (not empty)
//   i_ready    in   downstream accepts o_data this cycle
//   o_level    out  current occupancy
//   o_hwm      out  high-water mark of o_level
//   i_clr_hwm  in   reload o_hwm with next-cycle occupancy
//   o_drop_cnt out  8-bit saturating count of samples offered while full
module filter_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic [$clog2(DEPTH+1)-1:0]   o_hwm,
  input  logic                         i_clr_hwm,
  output logic [7:0]                   o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [LW-1:0]    level_nxt;
  logic [LW-1:0]    hwm;
  logic [7:0]       drop_cnt;
  logic             push;
  logic             pop;

  // Flow control comes from the registered level only, so o_ready has no
  // path from i_ready: a full FIFO refuses a push even while it is popping.
  assign o_ready = (level != LW'(DEPTH));
  assign o_valid = (level != '0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // Gate the head so stale or never-written storage is never visible.
  assign o_data  = o_valid ? mem[rd_ptr] : '0;

  assign o_level    = level;
  assign o_hwm      = hwm;
  assign o_drop_cnt = drop_cnt;

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level - LW'(1);
    end
  end

  // Storage carries no reset; only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the AW-bit pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      hwm      <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_nxt;
      if (i_clr_hwm) begin
        hwm <= level_nxt;
      end else if (level_nxt > hwm) begin
        hwm <= level_nxt;
      end
      if (i_valid && !o_ready && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
